// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - keypad-driven sequencer for the calculator datapath
module calc_seq_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [1:0]   key_type,
    input  logic [3:0]   key_val,
    output logic [N-1:0] operand,
    output logic         ld_a,
    output logic         ld_b,
    output logic [1:0]   op_sel,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic         alu_err,
    output logic         ld_res,
    output logic         clr_regs,
    output logic [1:0]   disp_sel,
    output logic         busy,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER_A,
        S_LOAD_A,
        S_ENTER_B,
        S_LOAD_B,
        S_EXEC,
        S_SHOW,
        S_ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] tcount;
    logic          b_dig;

    logic [N+3:0]  acc_next;
    logic          digit_ok;
    logic          digit_fits;
    logic          is_clear;
    logic          is_digit;
    logic          is_op;
    logic          is_eq;

    // Key decode and the widened operand*10+d candidate; clear bypasses busy
    always_comb begin
        acc_next   = ({4'b0000, operand} << 3) + ({4'b0000, operand} << 1)
                   + {{N{1'b0}}, key_val};
        digit_ok   = (key_val <= 4'd9);
        digit_fits = digit_ok && (acc_next[N+3:N] == 4'b0000);
        is_clear   = key_valid && (key_type == 2'd3);
        is_digit   = key_valid && !busy && (key_type == 2'd0);
        is_op      = key_valid && !busy && (key_type == 2'd1);
        is_eq      = key_valid && !busy && (key_type == 2'd2);
    end

    // Sequencer: every output is registered and pulses default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            operand   <= '0;
            op_sel    <= 2'd0;
            disp_sel  <= 2'd0;
            ld_a      <= 1'b0;
            ld_b      <= 1'b0;
            alu_start <= 1'b0;
            ld_res    <= 1'b0;
            clr_regs  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            tcount    <= '0;
            b_dig     <= 1'b0;
        end else begin
            ld_a      <= 1'b0;
            ld_b      <= 1'b0;
            alu_start <= 1'b0;
            ld_res    <= 1'b0;
            clr_regs  <= 1'b0;
            busy      <= 1'b0;
            if (is_clear) begin
                // Clear wins over everything, including a same-cycle alu_done
                clr_regs <= 1'b1;
                busy     <= 1'b1;
                operand  <= '0;
                op_sel   <= 2'd0;
                disp_sel <= 2'd0;
                err      <= 1'b0;
                tcount   <= '0;
                b_dig    <= 1'b0;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_digit && digit_ok) begin
                            operand <= N'(key_val);
                            state   <= S_ENTER_A;
                        end else if (is_op) begin
                            operand <= '0;
                            op_sel  <= key_val[1:0];
                            ld_a    <= 1'b1;
                            busy    <= 1'b1;
                            state   <= S_LOAD_A;
                        end
                    end
                    S_ENTER_A: begin
                        if (is_digit && digit_fits) begin
                            operand <= acc_next[N-1:0];
                        end else if (is_op) begin
                            op_sel <= key_val[1:0];
                            ld_a   <= 1'b1;
                            busy   <= 1'b1;
                            state  <= S_LOAD_A;
                        end
                    end
                    S_LOAD_A: begin
                        // operand was held through the ld_a cycle; now start B fresh
                        operand <= '0;
                        b_dig   <= 1'b0;
                        state   <= S_ENTER_B;
                    end
                    S_ENTER_B: begin
                        if (is_digit && digit_ok) begin
                            b_dig <= 1'b1;
                            if (digit_fits) begin
                                operand <= acc_next[N-1:0];
                            end
                        end else if (is_op && !b_dig) begin
                            op_sel <= key_val[1:0];
                        end else if (is_eq) begin
                            ld_b  <= 1'b1;
                            busy  <= 1'b1;
                            state <= S_LOAD_B;
                        end
                    end
                    S_LOAD_B: begin
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        tcount    <= '0;
                        state     <= S_EXEC;
                    end
                    S_EXEC: begin
                        busy <= 1'b1;
                        if (alu_done && !alu_err) begin
                            ld_res   <= 1'b1;
                            disp_sel <= 2'd1;
                            state    <= S_SHOW;
                        end else if (alu_done || (tcount == CW'(TIMEOUT - 1))) begin
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            disp_sel <= 2'd2;
                            state    <= S_ERROR;
                        end else begin
                            tcount <= tcount + CW'(1);
                        end
                    end
                    S_SHOW: begin
                        if (is_digit && digit_ok) begin
                            operand  <= N'(key_val);
                            disp_sel <= 2'd0;
                            state    <= S_ENTER_A;
                        end
                    end
                    default: begin
                        // Error holds until a clear key arrives
                        state <= S_ERROR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb/tb_calc_seq_ctrl.sv - directed self-checking bench for calc_seq_ctrl
module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key_type = 2'd0;
    logic [3:0] key_val = 4'd0;
    logic [7:0] operand;
    logic       ld_a, ld_b, alu_start, ld_res, clr_regs;
    logic [1:0] op_sel, disp_sel;
    logic       alu_done = 1'b0;
    logic       alu_err = 1'b0;
    logic       busy, err;
    logic [4:0] pulses;
    logic [4:0] prev_pulses = 5'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    calc_seq_ctrl #(.N(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_type(key_type),
        .key_val(key_val), .operand(operand), .ld_a(ld_a), .ld_b(ld_b),
        .op_sel(op_sel), .alu_start(alu_start), .alu_done(alu_done),
        .alu_err(alu_err), .ld_res(ld_res), .clr_regs(clr_regs),
        .disp_sel(disp_sel), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    assign pulses = {ld_a, ld_b, alu_start, ld_res, clr_regs};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [1:0] t, input logic [3:0] v);
        key_valid = 1'b1;
        key_type  = t;
        key_val   = v;
        step();
        key_valid = 1'b0;
    endtask

    // Pulses must be mutually exclusive and last a single cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("pulse_onehot", 32'($countones(pulses) <= 1), 1);
            chk("pulse_len", 32'(|(pulses & prev_pulses)), 0);
        end
        prev_pulses <= pulses;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_operand", operand, 0);
        chk("rst_pulses", pulses, 0);
        chk("rst_disp", disp_sel, 0);
        chk("rst_busy_err", {busy, err}, 0);
        rst = 1'b0;
        step();

        // 1: 12 op0 34 = with ALU done three cycles after start
        key(2'd0, 4'd1);  chk("t1_d1", operand, 1);
        key(2'd0, 4'd2);  chk("t1_d12", operand, 12);
        key(2'd1, 4'd0);  chk("t1_lda", pulses, 5'b10000);
        chk("t1_lda_opnd", operand, 12);
        chk("t1_lda_busy", busy, 1);
        step();           chk("t1_after_lda", {pulses, busy}, 0);
        chk("t1_opnd_clr", operand, 0);
        key(2'd0, 4'd3);
        key(2'd0, 4'd4);  chk("t1_b34", operand, 34);
        key(2'd2, 4'd0);  chk("t1_ldb", pulses, 5'b01000);
        chk("t1_ldb_opnd", operand, 34);
        step();           chk("t1_start", pulses, 5'b00100);
        chk("t1_start_busy", busy, 1);
        repeat (3) step();
        chk("t1_wait", pulses, 0);
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("t1_ldres", pulses, 5'b00010);
        chk("t1_disp", disp_sel, 1);
        step();           chk("t1_show_busy", {pulses, busy}, 0);
        key(2'd2, 4'd0);  chk("t1_show_eq", pulses, 0);
        chk("t1_show_disp", disp_sel, 1);
        key(2'd0, 4'd5);  chk("t1_show_digit", operand, 5);
        chk("t1_show_disp0", disp_sel, 0);

        // 2: saturation at 255, digit >9 ignored, operator replacement in B
        key(2'd3, 4'd0);  chk("t2_clr", pulses, 5'b00001);
        step();
        key(2'd0, 4'd2);
        key(2'd0, 4'd5);
        key(2'd0, 4'd5);  chk("t2_255", operand, 255);
        key(2'd0, 4'd6);  chk("t2_ovf", operand, 255);
        key(2'd0, 4'd12); chk("t2_d12", operand, 255);
        key(2'd1, 4'd2);  chk("t2_opsel", op_sel, 2);
        step();
        key(2'd1, 4'd1);  chk("t2_op_replace", op_sel, 1);
        chk("t2_no_ld", pulses, 0);
        key(2'd0, 4'd4);  chk("t2_b4", operand, 4);
        key(2'd1, 4'd3);  chk("t2_op_ignored", op_sel, 1);

        // 3: ALU error path and recovery by clear
        key(2'd3, 4'd0);
        step();
        key(2'd0, 4'd7);
        key(2'd1, 4'd3);  chk("t3_lda", {pulses, 8'(operand)}, {5'b10000, 8'd7});
        step();
        key(2'd0, 4'd0);
        key(2'd2, 4'd0);
        step();           chk("t3_start", pulses, 5'b00100);
        alu_done = 1'b1;
        alu_err  = 1'b1;
        step();
        alu_done = 1'b0;
        alu_err  = 1'b0;
        chk("t3_err", {err, disp_sel}, {1'b1, 2'd2});
        chk("t3_no_ldres", pulses, 0);
        key(2'd0, 4'd5);  chk("t3_digit_ign", operand, 0);
        key(2'd2, 4'd0);  chk("t3_eq_ign", {pulses, err}, {5'b00000, 1'b1});
        key(2'd3, 4'd0);  chk("t3_clr", pulses, 5'b00001);
        chk("t3_clr_state", {err, disp_sel, op_sel}, 0);
        step();

        // 4: ALU never answers, timeout lands 16 cycles after alu_start
        key(2'd0, 4'd1);
        key(2'd1, 4'd0);
        step();
        key(2'd0, 4'd2);
        key(2'd2, 4'd0);
        step();           chk("t4_start", pulses, 5'b00100);
        repeat (15) step();
        chk("t4_not_yet", {err, busy}, {1'b0, 1'b1});
        step();           chk("t4_timeout", {err, disp_sel}, {1'b1, 2'd2});
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        chk("t4_late_done", {pulses, err, disp_sel}, {5'b00000, 1'b1, 2'd2});

        // 5: busy-cycle key dropped; clear beats same-cycle alu_done
        key(2'd3, 4'd0);
        step();
        key(2'd0, 4'd6);
        key(2'd1, 4'd1);  chk("t5_lda", pulses, 5'b10000);
        key(2'd0, 4'd9);  chk("t5_busy_drop", operand, 0);
        step();           chk("t5_busy_drop2", operand, 0);
        key(2'd0, 4'd8);
        key(2'd2, 4'd0);
        step();
        step();
        key_valid = 1'b1;
        key_type  = 2'd3;
        alu_done  = 1'b1;
        step();
        key_valid = 1'b0;
        alu_done  = 1'b0;
        chk("t5_clr_wins", pulses, 5'b00001);
        chk("t5_operand", operand, 0);
        step();           chk("t5_no_ldres", {pulses, disp_sel}, 0);

        // 6: async reset mid-cycle in ENTER_B
        key(2'd0, 4'd1);
        key(2'd1, 4'd0);
        step();
        key(2'd0, 4'd9);  chk("t6_b9", operand, 9);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_opnd", operand, 0);
        chk("t6_async_rest", {pulses, op_sel, disp_sel, busy, err}, 0);
        step();
        rst = 1'b0;
        step();
        key(2'd0, 4'd3);  chk("t6_d3", operand, 3);
        key(2'd0, 4'd1);  chk("t6_d31", operand, 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
